// File: rtl/handshake_reg_chain_sink_if.sv
// Valid/ready bus between a source driver and the register-chain sink.
interface handshake_reg_chain_sink_if #(
    parameter int unsigned WIDTH = 9
);
    logic             src_vaild;
    logic [WIDTH-1:0] src_data_in;
    logic             src_ready;
    logic             ready_in;
    logic             dst_vaild;
    logic [WIDTH-1:0] dst_data;
    logic             dst_ready;

    modport master (
        output src_vaild, src_data_in, ready_in,
        input  src_ready, dst_vaild, dst_data, dst_ready
    );

    modport slave (
        input  src_vaild, src_data_in, ready_in,
        output src_ready, dst_vaild, dst_data, dst_ready
    );
endinterface

// File: rtl/handshake_reg_chain_sink.sv
// Skid slice feeding a forward register slice, drained by a sequence-checking consumer.
module handshake_reg_chain_sink #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       s_rst,
    handshake_reg_chain_sink_if.slave  bus,
    output logic                       idle,
    output logic                       start,
    output logic                       err,
    output logic [15:0]                rx_cnt
);
    localparam int unsigned CNT_W = 16;
    localparam logic [0:0]  EMPTY = 1'b0;
    localparam logic [0:0]  FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_nxt;
    logic             skid_load;
    logic             mid_valid;
    logic [WIDTH-1:0] mid_data;
    logic             mid_ready;
    logic             xfer;

    assign mid_ready = !bus.dst_vaild || bus.dst_ready;
    assign xfer      = bus.dst_vaild && bus.dst_ready;
    assign exp_nxt   = WIDTH'((32'(bus.dst_data) + 32'd1) % DEPTH);

    // Skid state register
    always_ff @(posedge clk or negedge s_rst) begin
        if (!s_rst) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Skid next state and middle handshake; src_ready gates pass-through so
    // nothing is taken before the upstream handshake actually completes.
    always_comb begin
        state_d   = state_q;
        skid_load = 1'b0;
        mid_valid = 1'b0;
        mid_data  = skid_q;
        case (state_q)
            EMPTY: begin
                mid_valid = bus.src_vaild && bus.src_ready;
                mid_data  = bus.src_data_in;
                if (bus.src_vaild && bus.src_ready && !mid_ready) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end
            end
            FULL: begin
                mid_valid = 1'b1;
                if (mid_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Datapath: skid storage, forward slice, consumer and checker
    always_ff @(posedge clk or negedge s_rst) begin
        if (!s_rst) begin
            bus.src_ready <= 1'b0;
            idle          <= 1'b1;
            skid_q        <= '0;
            bus.dst_vaild <= 1'b0;
            bus.dst_data  <= '0;
            bus.dst_ready <= 1'b0;
            start         <= 1'b0;
            err           <= 1'b0;
            exp_q         <= '0;
            rx_cnt        <= '0;
        end else begin
            bus.src_ready <= (state_d == EMPTY);
            idle          <= (state_d == EMPTY);
            if (skid_load) skid_q <= bus.src_data_in;
            if (mid_ready) begin
                bus.dst_vaild <= mid_valid;
                if (mid_valid) bus.dst_data <= mid_data;
            end
            // dst_vaild can only rise when empty, and then mid_ready is 1
            start         <= mid_valid && !bus.dst_vaild;
            bus.dst_ready <= bus.ready_in;
            if (xfer) begin
                if (bus.dst_data != exp_q) err <= 1'b1;
                exp_q  <= exp_nxt;
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_handshake_reg_chain_sink.sv
// Self-checking bench: scoreboard on both handshakes plus a cycle table for backpressure.
module tb_handshake_reg_chain_sink;
    localparam int unsigned WIDTH = 9;
    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        s_rst;
    logic        idle, start, err;
    logic [15:0] rx_cnt;

    handshake_reg_chain_sink_if #(.WIDTH(WIDTH)) bus ();

    handshake_reg_chain_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .s_rst  (s_rst),
        .bus    (bus),
        .idle   (idle),
        .start  (start),
        .err    (err),
        .rx_cnt (rx_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb[$];
    int  push_cnt  = 0;
    int  start_cnt = 0;
    bit  saw_wrap  = 0;
    int  prev_out  = -1;
    bit  fired     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard: push on source handshake, pop/compare on destination transfer
    always @(negedge clk) begin
        if (s_rst) begin
            if (bus.src_vaild && bus.src_ready) begin
                sb.push_back(bus.src_data_in);
                push_cnt++;
            end
            if (bus.dst_vaild && bus.dst_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("sb_data", 32'(bus.dst_data), 32'(sb.pop_front()));
                if (prev_out == 255 && bus.dst_data == 0) saw_wrap = 1;
                prev_out = int'(bus.dst_data);
            end
            if (start) start_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        fired = bus.src_vaild && bus.src_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        s_rst = 1'b0;
        bus.src_vaild = 1'b0;
        bus.src_data_in = '0;
        bus.ready_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        sb.delete();
        push_cnt = 0; start_cnt = 0; saw_wrap = 0; prev_out = -1;
        s_rst = 1'b1;
        step();
    endtask

    task automatic send_words(input int first, input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 1000) begin
            bus.src_vaild = 1'b1;
            bus.src_data_in = WIDTH'(first + k);
            step();
            if (fired) k++;
            guard++;
        end
        bus.src_vaild = 1'b0;
        chk("send_done", 32'(k), 32'(n));
    endtask

    task automatic drain();
        int g = 0;
        bus.ready_in = 1'b1;
        while ((sb.size() != 0 || bus.dst_vaild) && g < 200) begin
            step();
            g++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             ri;
        logic             e_src_ready;
        logic             e_dst_vaild;
        logic [WIDTH-1:0] e_dst_data;
        logic             e_dst_ready;
        logic             e_idle;
    } vec_t;

    vec_t bp_tab[7];

    initial begin
        int seq, presented, g;

        bp_tab[0] = '{1'b1, 9'd5, 1'b0, 1'b1, 1'b1, 9'd5, 1'b0, 1'b1};
        bp_tab[1] = '{1'b1, 9'd6, 1'b0, 1'b0, 1'b1, 9'd5, 1'b0, 1'b0};
        bp_tab[2] = '{1'b1, 9'd7, 1'b0, 1'b0, 1'b1, 9'd5, 1'b0, 1'b0};
        bp_tab[3] = '{1'b1, 9'd7, 1'b1, 1'b0, 1'b1, 9'd5, 1'b1, 1'b0};
        bp_tab[4] = '{1'b1, 9'd7, 1'b1, 1'b1, 1'b1, 9'd6, 1'b1, 1'b1};
        bp_tab[5] = '{1'b1, 9'd7, 1'b1, 1'b1, 1'b1, 9'd7, 1'b1, 1'b1};
        bp_tab[6] = '{1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 9'd7, 1'b1, 1'b1};

        // Reset then idle
        s_rst = 1'b0;
        bus.src_vaild = 1'b0;
        bus.src_data_in = '0;
        bus.ready_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
        chk("rst_dst_vaild", 32'(bus.dst_vaild), 32'd0);
        chk("rst_dst_data",  32'(bus.dst_data),  32'd0);
        chk("rst_dst_ready", 32'(bus.dst_ready), 32'd0);
        chk("rst_idle",      32'(idle),          32'd1);
        chk("rst_start",     32'(start),         32'd0);
        chk("rst_err",       32'(err),           32'd0);
        chk("rst_rx_cnt",    32'(rx_cnt),        32'd0);
        s_rst = 1'b1;
        #1;
        chk("rel_src_ready_pre", 32'(bus.src_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rel_src_ready_post", 32'(bus.src_ready), 32'd1);

        // Streaming 0..20 with one-cycle latency
        do_reset(2);
        bus.ready_in = 1'b1;
        step();
        step();
        for (int w = 0; w <= 20; w++) begin
            g = 0;
            bus.src_vaild = 1'b1;
            bus.src_data_in = WIDTH'(w);
            step();
            while (!fired && g < 20) begin step(); g++; end
            chk("stream_lat", {23'd0, bus.dst_vaild, bus.dst_data}, {23'd0, 1'b1, WIDTH'(w)});
        end
        bus.src_vaild = 1'b0;
        drain();
        chk("stream_start_cnt", 32'(start_cnt), 32'd1);
        chk("stream_err",       32'(err),       32'd0);
        chk("stream_rx_cnt",    32'(rx_cnt),    32'd21);

        // Backpressure table
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            bus.src_vaild = bp_tab[i].v;
            bus.src_data_in = bp_tab[i].d;
            bus.ready_in = bp_tab[i].ri;
            step();
            chk($sformatf("bp%0d_src_ready", i), 32'(bus.src_ready), 32'(bp_tab[i].e_src_ready));
            chk($sformatf("bp%0d_dst_vaild", i), 32'(bus.dst_vaild), 32'(bp_tab[i].e_dst_vaild));
            chk($sformatf("bp%0d_dst_data",  i), 32'(bus.dst_data),  32'(bp_tab[i].e_dst_data));
            chk($sformatf("bp%0d_dst_ready", i), 32'(bus.dst_ready), 32'(bp_tab[i].e_dst_ready));
            chk($sformatf("bp%0d_idle",      i), 32'(idle),          32'(bp_tab[i].e_idle));
        end
        drain();
        chk("bp_rx_cnt", 32'(rx_cnt), 32'd3);

        // Random stress, then a full-rate tail until the sequence wraps
        do_reset(2);
        seq = 0; presented = 0; fired = 0;
        for (int c = 0; c < 300; c++) begin
            if (!bus.src_vaild || fired) begin
                if ($urandom_range(3) != 0) begin
                    bus.src_vaild = 1'b1;
                    bus.src_data_in = WIDTH'(seq);
                    seq = (seq + 1) % DEPTH;
                    presented++;
                end else begin
                    bus.src_vaild = 1'b0;
                end
            end
            bus.ready_in = ($urandom_range(3) != 0);
            step();
        end
        bus.ready_in = 1'b1;
        for (int c = 0; c < 2000 && presented < 270; c++) begin
            if (!bus.src_vaild || fired) begin
                bus.src_vaild = 1'b1;
                bus.src_data_in = WIDTH'(seq);
                seq = (seq + 1) % DEPTH;
                presented++;
            end
            step();
        end
        g = 0;
        while (bus.src_vaild && !fired && g < 50) begin step(); g++; end
        bus.src_vaild = 1'b0;
        drain();
        chk("rand_err",      32'(err),      32'd0);
        chk("rand_rx_cnt",   32'(rx_cnt),   32'(16'(push_cnt)));
        chk("rand_accepted", 32'(push_cnt), 32'(presented));
        chk("rand_wrap",     32'(saw_wrap), 32'd1);

        // Mismatch on 0,1,3
        do_reset(2);
        bus.ready_in = 1'b1;
        step();
        send_words(0, 2);
        send_words(3, 1);
        drain();
        chk("mm_err",  32'(err),       32'd1);
        chk("mm_exp",  32'(dut.exp_q), 32'd4);
        repeat (4) step();
        chk("mm_err_sticky", 32'(err), 32'd1);

        // Reset mid-stream with both stages full
        do_reset(2);
        send_words(0, 2);
        chk("mrs_full_dv",   32'(bus.dst_vaild), 32'd1);
        chk("mrs_full_idle", 32'(idle),          32'd0);
        chk("mrs_full_sr",   32'(bus.src_ready), 32'd0);
        #2;
        s_rst = 1'b0;
        #1;
        chk("mrs_rst_dv",   32'(bus.dst_vaild), 32'd0);
        chk("mrs_rst_idle", 32'(idle),          32'd1);
        do_reset(1);
        bus.ready_in = 1'b1;
        step();
        send_words(0, 5);
        drain();
        chk("mrs_err",    32'(err),    32'd0);
        chk("mrs_rx_cnt", 32'(rx_cnt), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
